// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2,
    EXEC  = 2'd3
  } state_t;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 4;

  function automatic int lat_clamp(input int lat);
    if (lat < MEM_LAT_MIN) return MEM_LAT_MIN;
    if (lat > MEM_LAT_MAX) return MEM_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory read port plus fetch-to-decode handshake.
interface fetch_if;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;

  modport master (
    output imem_en, imem_addr,
    input  imem_rdata,
    output inst, inst_pc, inst_valid,
    input  inst_ready
  );

  modport slave (
    input  imem_en, imem_addr,
    output imem_rdata,
    input  inst, inst_pc, inst_valid,
    output inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Multi-cycle fetch sequencer: issue read, wait for data, hand to
// decode, then wait for execute to commit the next PC.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
  parameter int          MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        halt,
  fetch_if.master     bus,
  output logic [31:0] cpc,
  input  logic [31:0] npc,
  input  logic        npc_we,
  output logic [31:0] fetch_count,
  output logic        err
);

  localparam int LAT = lat_clamp(MEM_LATENCY);
  localparam logic [1:0] CNT_INIT = 2'(LAT - 1);

  state_t      state;
  logic [1:0]  cnt;
  logic [31:0] inst_q;
  logic [31:0] pc_q;

  // rstn gates the strobe so no read leaves while reset is held
  assign bus.imem_en    = rstn & (state == FETCH) & ~halt;
  assign bus.imem_addr  = cpc;
  assign bus.inst_valid = (state == ISSUE);
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = pc_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= FETCH;
      cnt         <= 2'd0;
      cpc         <= RESET_PC;
      inst_q      <= 32'd0;
      pc_q        <= 32'd0;
      fetch_count <= 32'd0;
      err         <= 1'b0;
    end else begin
      if (npc_we && state != EXEC)
        err <= 1'b1;
      unique case (state)
        FETCH: begin
          if (!halt) begin
            state <= WAIT;
            cnt   <= CNT_INIT;
          end
        end
        WAIT: begin
          if (cnt == 2'd0) begin
            inst_q <= bus.imem_rdata;
            pc_q   <= cpc;
            state  <= ISSUE;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        ISSUE: begin
          if (bus.inst_ready) begin
            fetch_count <= fetch_count + 32'd1;
            state       <= EXEC;
          end
        end
        EXEC: begin
          if (npc_we) begin
            cpc   <= {npc[31:2], 2'b00};
            state <= FETCH;
            if (npc[1:0] != 2'b00)
              err <= 1'b1;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit at latencies 2, 1 and 4.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rstn;
  logic halt;
  logic h2;
  logic [31:0] npc;
  logic npc_we;
  logic [31:0] cpc, fcnt;
  logic err;
  logic [31:0] cpc1, fcnt1, cpc4, fcnt4;
  logic err1, err4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_if bus ();
  fetch_if b1 ();
  fetch_if b4 ();

  fetch_unit #(.RESET_PC(32'h0), .MEM_LATENCY(2)) dut (
    .clk(clk), .rstn(rstn), .halt(halt), .bus(bus),
    .cpc(cpc), .npc(npc), .npc_we(npc_we),
    .fetch_count(fcnt), .err(err)
  );

  fetch_unit #(.RESET_PC(32'h0), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .rstn(rstn), .halt(h2), .bus(b1),
    .cpc(cpc1), .npc(32'h0), .npc_we(1'b0),
    .fetch_count(fcnt1), .err(err1)
  );

  fetch_unit #(.RESET_PC(32'h0), .MEM_LATENCY(4)) dut4 (
    .clk(clk), .rstn(rstn), .halt(h2), .bus(b4),
    .cpc(cpc4), .npc(32'h0), .npc_we(1'b0),
    .fetch_count(fcnt4), .err(err4)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    return {16'h1000, a[15:0]};
  endfunction

  // Read data appears exactly N cycles after the strobe cycle
  logic [31:0] pa [1:4];
  logic [31:0] pb [1:4];
  logic [31:0] pc4 [1:4];

  always @(posedge clk) begin
    pa[1]  <= bus.imem_en ? mem(bus.imem_addr) : DEAD;
    pb[1]  <= b1.imem_en ? mem(b1.imem_addr) : DEAD;
    pc4[1] <= b4.imem_en ? mem(b4.imem_addr) : DEAD;
    for (int k = 2; k <= 4; k++) begin
      pa[k]  <= pa[k-1];
      pb[k]  <= pb[k-1];
      pc4[k] <= pc4[k-1];
    end
  end

  assign bus.imem_rdata = pa[2];
  assign b1.imem_rdata  = pb[1];
  assign b4.imem_rdata  = pc4[4];
  assign b1.inst_ready  = 1'b1;
  assign b4.inst_ready  = 1'b1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] npc;
    logic [31:0] cpc;
    logic [31:0] cnt;
    logic        err;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.inst_valid && n < 12);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_en"}, {31'd0, bus.imem_en}, 32'd0);
    chk({tag, "_valid"}, {31'd0, bus.inst_valid}, 32'd0);
    chk({tag, "_cpc"}, cpc, 32'd0);
    chk({tag, "_cnt"}, fcnt, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_inst"}, bus.inst, 32'd0);
    chk({tag, "_ipc"}, bus.inst_pc, 32'd0);
  endtask

  int n;
  int f1, f4;

  initial begin
    vecs[0] = '{32'h04, 32'h1000_0004, 32'h08, 32'h08, 32'd2, 1'b0};
    vecs[1] = '{32'h08, 32'h1000_0008, 32'h0C, 32'h0C, 32'd3, 1'b0};
    vecs[2] = '{32'h0C, 32'h1000_000C, 32'h10, 32'h10, 32'd4, 1'b0};
    vecs[3] = '{32'h10, 32'h1000_0010, 32'h14, 32'h14, 32'd5, 1'b0};
    vecs[4] = '{32'h14, 32'h1000_0014, 32'h18, 32'h18, 32'd6, 1'b0};
    vecs[5] = '{32'h18, 32'h1000_0018, 32'h1C, 32'h1C, 32'd7, 1'b0};
    vecs[6] = '{32'h1C, 32'h1000_001C, 32'h102, 32'h100, 32'd8, 1'b1};
    vecs[7] = '{32'h100, 32'h1000_0100, 32'h104, 32'h104, 32'd9, 1'b1};

    rstn = 1'b0;
    halt = 1'b0;
    h2 = 1'b0;
    npc = 32'd0;
    npc_we = 1'b0;
    bus.inst_ready = 1'b0;
    repeat (2) tick();
    chk_reset("rst");

    // First fetch after reset release
    rstn = 1'b1;
    #1;
    chk("c0_en", {31'd0, bus.imem_en}, 32'd1);
    chk("c0_addr", bus.imem_addr, 32'd0);
    tick();
    chk("c1_valid", {31'd0, bus.inst_valid}, 32'd0);
    tick();
    chk("c2_valid", {31'd0, bus.inst_valid}, 32'd0);
    tick();
    chk("c3_valid", {31'd0, bus.inst_valid}, 32'd1);
    chk("c3_inst", bus.inst, 32'h2008_0005);
    chk("c3_ipc", bus.inst_pc, 32'd0);

    // Backpressure
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("bp_valid", {31'd0, bus.inst_valid}, 32'd1);
      chk("bp_inst", bus.inst, 32'h2008_0005);
      chk("bp_ipc", bus.inst_pc, 32'd0);
      chk("bp_cnt", fcnt, 32'd0);
    end
    bus.inst_ready = 1'b1;
    tick();
    chk("bp_xfer_cnt", fcnt, 32'd1);
    chk("bp_exec_valid", {31'd0, bus.inst_valid}, 32'd0);
    npc = 32'h4;
    npc_we = 1'b1;
    tick();
    npc_we = 1'b0;

    // Sequential run and misaligned redirect
    for (int i = 0; i < 8; i++) begin
      chk("seq_en", {31'd0, bus.imem_en}, 32'd1);
      chk("seq_addr", bus.imem_addr, vecs[i].addr);
      wait_valid(n);
      chk("seq_lat", n, 32'd3);
      chk("seq_inst", bus.inst, vecs[i].inst);
      chk("seq_ipc", bus.inst_pc, vecs[i].addr);
      tick();
      chk("seq_cnt", fcnt, vecs[i].cnt);
      npc = vecs[i].npc;
      npc_we = 1'b1;
      tick();
      npc_we = 1'b0;
      chk("seq_cpc", cpc, vecs[i].cpc);
      chk("seq_err", {31'd0, err}, {31'd0, vecs[i].err});
    end

    // Stray npc_we during WAIT
    tick();
    npc = 32'h200;
    npc_we = 1'b1;
    tick();
    npc_we = 1'b0;
    chk("wait_we_cpc", cpc, 32'h104);
    chk("wait_we_err", {31'd0, err}, 32'd1);
    wait_valid(n);
    chk("wait_we_inst", bus.inst, 32'h1000_0104);
    tick();
    npc = 32'h108;
    npc_we = 1'b1;
    tick();
    npc_we = 1'b0;

    // Halt in FETCH
    halt = 1'b1;
    #1;
    chk("halt_en0", {31'd0, bus.imem_en}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("halt_en", {31'd0, bus.imem_en}, 32'd0);
      chk("halt_addr", bus.imem_addr, 32'h108);
      chk("halt_valid", {31'd0, bus.inst_valid}, 32'd0);
    end
    halt = 1'b0;
    #1;
    chk("unhalt_en", {31'd0, bus.imem_en}, 32'd1);
    wait_valid(n);
    chk("unhalt_lat", n, 32'd3);
    chk("unhalt_inst", bus.inst, 32'h1000_0108);
    tick();
    npc = 32'h10C;
    npc_we = 1'b1;
    tick();
    npc_we = 1'b0;

    // Reset during WAIT; stale read of 0x10C must not surface
    tick();
    rstn = 1'b0;
    #1;
    chk_reset("rw");
    tick();
    rstn = 1'b1;
    #1;
    chk("rw_en", {31'd0, bus.imem_en}, 32'd1);
    chk("rw_addr", bus.imem_addr, 32'd0);
    wait_valid(n);
    chk("rw_lat", n, 32'd3);
    chk("rw_inst", bus.inst, 32'h2008_0005);
    chk("rw_ipc", bus.inst_pc, 32'd0);

    // Stray npc_we during ISSUE, then reset in ISSUE
    bus.inst_ready = 1'b0;
    npc = 32'h40;
    npc_we = 1'b1;
    tick();
    npc_we = 1'b0;
    chk("iss_we_err", {31'd0, err}, 32'd1);
    chk("iss_we_cpc", cpc, 32'd0);
    chk("iss_we_valid", {31'd0, bus.inst_valid}, 32'd1);
    rstn = 1'b0;
    #1;
    chk_reset("ri");
    tick();
    rstn = 1'b1;
    #1;
    chk("ri_en", {31'd0, bus.imem_en}, 32'd1);
    wait_valid(n);
    chk("ri_lat", n, 32'd3);
    chk("ri_inst", bus.inst, 32'h2008_0005);

    // Latency 1 and 4 with halt held after reset
    rstn = 1'b0;
    h2 = 1'b1;
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("l1_halt_en", {31'd0, b1.imem_en}, 32'd0);
      chk("l4_halt_en", {31'd0, b4.imem_en}, 32'd0);
      tick();
    end
    h2 = 1'b0;
    #1;
    chk("l1_en", {31'd0, b1.imem_en}, 32'd1);
    chk("l4_en", {31'd0, b4.imem_en}, 32'd1);
    f1 = 0;
    f4 = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (b1.inst_valid && f1 == 0) f1 = k;
      if (b4.inst_valid && f4 == 0) f4 = k;
      if (f1 == 1 || f1 == 2) chk("l1_inst_hold", b1.inst, 32'h2008_0005);
    end
    chk("l1_lat", f1, 32'd2);
    chk("l4_lat", f4, 32'd5);
    chk("l4_inst", b4.inst, 32'h2008_0005);
    chk("l1_cnt", fcnt1, 32'd1);
    chk("l4_cnt", fcnt4, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch sequencer for the multi-cycle core. Holds the architectural PC (exported as `cpc`), issues one read per instruction to the synchronous instruction memory, and hands the fetched word to decode over a valid/ready handshake. It then waits for execute to return the next PC computed by the next-PC logic, loads it, and starts the next fetch.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `MEM_LATENCY`, default 2: cycles from the `imem_en` cycle to valid `imem_rdata`. Legal range 1..4.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rstn`  in  1: reset, asynchronous and active-low.
- `halt`  in  1: blocks new fetch issue while high.
- `imem_en`  out  1: read strobe to instruction memory.
- `imem_addr`  out  32: byte address of the read; always equals `cpc`.
- `imem_rdata`  in  32: read data, valid exactly `MEM_LATENCY` cycles after the `imem_en` cycle.
- `inst`  out  32: fetched instruction word.
- `inst_pc`  out  32: PC of `inst`.
- `inst_valid`  out  1: `inst`/`inst_pc` are valid for decode.
- `inst_ready`  in  1: decode accepts the instruction.
- `cpc`  out  32: current PC, fed to next-PC logic.
- `npc`  in  32: next PC from next-PC logic.
- `npc_we`  in  1: execute commits `npc`.
- `fetch_count`  out  32: count of instructions accepted by decode.
- `err`  out  1: sticky protocol/alignment error flag.

## Operation
- FSM states: FETCH, WAIT, ISSUE, EXEC.
- FETCH: `imem_en` = !`halt`. If `halt`=0, go to WAIT and set the latency counter to `MEM_LATENCY`-1. If `halt`=1, stay in FETCH.
- WAIT: counter decrements each cycle. When the counter is 0, capture `imem_rdata` into `inst`, set `inst_pc` = `cpc`, and go to ISSUE.
- ISSUE: `inst_valid`=1. `inst` and `inst_pc` stay stable until `inst_ready`=1. On transfer, `fetch_count` increments (wraps at 2^32) and the FSM goes to EXEC.
- EXEC: wait for `npc_we`. On `npc_we`, `cpc` loads {`npc`[31:2],2'b00} and the FSM goes to FETCH. If `npc`[1:0]≠0, set `err`.
- `npc_we` outside EXEC is ignored (`cpc` unchanged) and sets `err`.
- `halt` affects only FETCH. A read already issued completes normally.
- `err` clears only on reset.
- `imem_en`, `inst_valid` and `imem_addr` are decoded from state and registers only, with no combinational path from inputs except `halt`→`imem_en`.

## Timing
- Reset values: state=FETCH, `cpc`=`RESET_PC`, `inst`=0, `inst_pc`=0, `inst_valid`=0, `fetch_count`=0, `err`=0. `imem_en` is 0 while `rstn`=0.
- Reset asserted mid-operation (any state) returns to the reset values immediately. An in-flight memory read is discarded: its data is never captured.
- Read issued in cycle t (FETCH) → `inst_valid`=1 from cycle t+`MEM_LATENCY`+1.
- `inst_ready` high in the first ISSUE cycle → EXEC next cycle.
- `npc_we` in EXEC cycle u → `cpc`=`npc` and `imem_en`=1 in cycle u+1.
- Minimum loop with `inst_ready`=1 and `npc_we` immediate: `MEM_LATENCY`+3 cycles per instruction.

## Structure
- A shared package `fetch_pkg` holds:
  - the FSM state encoding (2-bit, FETCH=0, WAIT=1, ISSUE=2, EXEC=3);
  - the default `RESET_PC`;
  - the `MEM_LATENCY` legal-range constants.
- Single module, no sub-modules. The latency counter is 2 bits, inline.

## Test plan
- Reset release, `RESET_PC`=0, `MEM_LATENCY`=2, memory returns 32'h2008_0005 at address 0 → `imem_en`=1 in cycle 0; `inst_valid`=1 in cycle 3 with `inst`=32'h2008_0005, `inst_pc`=0.
- Sequential run: `inst_ready`=1, `npc_we` pulsed in each EXEC with `npc`=`cpc`+4 over 8 instructions → `imem_addr` 0,4,…,28; `fetch_count`=8; 5 cycles per instruction.
- Backpressure: hold `inst_ready`=0 for 6 cycles in ISSUE → `inst` and `inst_pc` stable, `fetch_count` unchanged; `inst_ready`=1 → one increment, then EXEC.
- Redirect and alignment: `npc`=32'h0000_0102 in EXEC → `cpc`=32'h0000_0100 and `err`=1. A later `npc_we` pulse during WAIT → `cpc` unchanged, `err` stays 1.
- `halt`=1 in FETCH for 4 cycles → `imem_en`=0 and state held; `halt`=0 → `imem_en`=1 next cycle. Repeat with `MEM_LATENCY`=1 and 4 → `inst_valid` at issue+2 and issue+5.
- Assert `rstn`=0 during WAIT and during ISSUE → all outputs at reset values asynchronously; after release, the fetch restarts at `RESET_PC` and the stale read data is never presented.
